// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scans the oven's 4x3 membrane keypad, debounces whole scan
// frames, rejects multi-key presses and presents the committed key as a one-hot
// digit bus plus '*' and '#' levels, with a one-cycle strobe per newly committed key.
//
// Ports
//   clk         system clock, all logic on posedge
//   clearn      synchronous active-low reset
//   col_n[2:0]  matrix columns from the pads (active-low, pulled up, asynchronous)
//   row_n[3:0]  matrix row drive, exactly one bit low
//   keypad[9:0] one-hot committed digit, bit k = key 'k', all zero = no digit
//   star        committed key is '*'
//   hash        committed key is '#'
//   key_strobe  one-cycle pulse when a new key commits
//
// Key layout (row r / col c):  r0: 1 2 3 | r1: 4 5 6 | r2: 7 8 9 | r3: * 0 #
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 4,  // clocks per row slot, >= 4
  parameter int unsigned DEBOUNCE_FRAMES = 3   // identical frames needed to commit, >= 1
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [9:0] keypad,
  output logic       star,
  output logic       hash,
  output logic       key_strobe
);

  localparam int unsigned SlotW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW  = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES + 1) : 1;

  localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]  CntLimit = CntW'(DEBOUNCE_FRAMES);

  // Frame codes: 0 = no key (also used for multi-key frames), 1..12 = key index + 1,
  // where key index = row * 3 + col.
  localparam logic [3:0] CodeNone = 4'd0;

  typedef enum logic [1:0] {
    StIdle,
    StHeld,
    StRelease
  } state_e;

  // Key code to {hash, star, keypad[9:0]}. Codes 1..9 are digits 1..9 directly.
  function automatic logic [11:0] decode_key(input logic [3:0] code);
    logic [11:0] res;
    res = '0;
    case (code)
      4'd1:    res[1]  = 1'b1;
      4'd2:    res[2]  = 1'b1;
      4'd3:    res[3]  = 1'b1;
      4'd4:    res[4]  = 1'b1;
      4'd5:    res[5]  = 1'b1;
      4'd6:    res[6]  = 1'b1;
      4'd7:    res[7]  = 1'b1;
      4'd8:    res[8]  = 1'b1;
      4'd9:    res[9]  = 1'b1;
      4'd10:   res[10] = 1'b1;  // '*'
      4'd11:   res[0]  = 1'b1;  // '0'
      4'd12:   res[11] = 1'b1;  // '#'
      default: res = '0;
    endcase
    return res;
  endfunction

  // Column synchronizer
  logic [2:0] col_s1_q, col_s2_q;

  // Scan timing
  logic [SlotW-1:0] slot_q, slot_d;
  logic [1:0]       row_q, row_d;
  logic             slot_last, frame_end;

  // Per-frame accumulation: number of low columns seen (saturating at 2) and the
  // index of the last single low column.
  logic [1:0] acc_lows_q, acc_lows_d;
  logic [3:0] acc_key_q, acc_key_d;

  // Debounce
  logic [3:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            hit;

  // Commit FSM and registered outputs
  state_e      state_q, state_d;
  logic [3:0]  held_q, held_d;
  logic [11:0] out_q, out_d;
  logic        strobe_q, strobe_d;

  // Combinational helpers
  logic [2:0] lows;
  logic [1:0] n_low;
  logic [1:0] low_col;
  logic [3:0] row_base;
  logic [3:0] key_here;
  logic [2:0] acc_sum;
  logic [1:0] sat_lows;
  logic [3:0] key_acc;
  logic [3:0] frame_code;

  always_ff @(posedge clk) begin
    if (!clearn) begin
      // Columns idle high (pulled up), so the synchronizer clears to "no contact".
      col_s1_q   <= 3'b111;
      col_s2_q   <= 3'b111;
      slot_q     <= '0;
      row_q      <= 2'd0;
      acc_lows_q <= 2'd0;
      acc_key_q  <= 4'd0;
      cand_q     <= CodeNone;
      cnt_q      <= '0;
      state_q    <= StIdle;
      held_q     <= CodeNone;
      out_q      <= '0;
      strobe_q   <= 1'b0;
    end else begin
      col_s1_q   <= col_n;
      col_s2_q   <= col_s1_q;
      slot_q     <= slot_d;
      row_q      <= row_d;
      acc_lows_q <= acc_lows_d;
      acc_key_q  <= acc_key_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      held_q     <= held_d;
      out_q      <= out_d;
      strobe_q   <= strobe_d;
    end
  end

  // Scan timing and per-slot column sampling
  always_comb begin
    slot_last = (slot_q == SlotLast);
    frame_end = slot_last && (row_q == 2'd3);

    slot_d = slot_q + SlotW'(1);
    row_d  = row_q;
    if (slot_last) begin
      slot_d = '0;
      row_d  = row_q + 2'd1;
    end

    lows  = ~col_s2_q;
    n_low = {1'b0, lows[0]} + {1'b0, lows[1]} + {1'b0, lows[2]};

    // Only meaningful when exactly one column is low.
    case (lows)
      3'b010:  low_col = 2'd1;
      3'b100:  low_col = 2'd2;
      default: low_col = 2'd0;
    endcase

    row_base = {1'b0, row_q, 1'b0} + {2'b00, row_q};  // row * 3
    key_here = row_base + {2'b00, low_col};

    acc_sum  = {1'b0, acc_lows_q} + {1'b0, n_low};
    sat_lows = (acc_sum >= 3'd2) ? 2'd2 : acc_sum[1:0];
    key_acc  = (n_low == 2'd1) ? key_here : acc_key_q;

    acc_lows_d = acc_lows_q;
    acc_key_d  = acc_key_q;
    if (slot_last) begin
      acc_lows_d = frame_end ? 2'd0 : sat_lows;
      acc_key_d  = key_acc;
    end

    // Including the final slot's sample: a single low column across the whole
    // frame is a key, anything more is treated as no key.
    frame_code = (sat_lows == 2'd1) ? (key_acc + 4'd1) : CodeNone;
  end

  // Debounce and commit FSM, both advance only at frame end
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    held_d   = held_q;
    out_d    = out_q;
    strobe_d = 1'b0;
    hit      = 1'b0;

    if (frame_end) begin
      if (frame_code == cand_q) begin
        if (cnt_q < CntLimit) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end else begin
        cand_d = frame_code;
        cnt_d  = CntW'(1);
      end
      hit = (cnt_d == CntLimit);

      unique case (state_q)
        StIdle: begin
          if (hit && (cand_d != CodeNone)) begin
            state_d  = StHeld;
            held_d   = cand_d;
            out_d    = decode_key(cand_d);
            strobe_d = 1'b1;
          end
        end
        StHeld: begin
          // Outputs stay asserted until the change is itself debounced.
          if (frame_code != held_q) begin
            state_d = StRelease;
          end
        end
        StRelease: begin
          if (hit) begin
            if (cand_d == CodeNone) begin
              state_d = StIdle;
              out_d   = '0;
            end else if (cand_d == held_q) begin
              state_d = StHeld;
            end else begin
              // Slide to a different key without an intervening release.
              state_d  = StHeld;
              held_d   = cand_d;
              out_d    = decode_key(cand_d);
              strobe_d = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign row_n      = ~(4'b0001 << row_q);
  assign keypad     = out_q[9:0];
  assign star       = out_q[10];
  assign hash       = out_q[11];
  assign key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed stimulus for keypad_scanner with a behavioural
// keypad/scan model that predicts row drive and committed outputs every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_keypad_scanner;

  localparam int SD = 4;   // clocks per row slot
  localparam int DF = 3;   // debounce frames
  localparam int FRAME = 4 * SD;

  // Key indices (row * 3 + col)
  localparam int K1 = 0, K3 = 2, K5 = 4, K7 = 6, K8 = 7, K9 = 8, KSTAR = 9, K0 = 10;

  logic       clk = 1'b0;
  logic       clearn;
  logic [2:0] col_n;
  logic [3:0] row_n;
  logic [9:0] keypad;
  logic       star, hash, key_strobe;

  logic [11:0] pressed;

  int checks = 0;
  int errors = 0;

  keypad_scanner #(
    .SCAN_DIV(SD),
    .DEBOUNCE_FRAMES(DF)
  ) dut (
    .clk(clk),
    .clearn(clearn),
    .col_n(col_n),
    .row_n(row_n),
    .keypad(keypad),
    .star(star),
    .hash(hash),
    .key_strobe(key_strobe)
  );

  always #5 clk = ~clk;

  // Membrane matrix: a pressed key shorts its column to its driven-low row.
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (pressed[r*3+c] && (row_n[r] === 1'b0)) col_n[c] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Key index -> {hash, star, keypad}
  function automatic logic [11:0] key_outputs(input int k);
    logic [11:0] o;
    int digit;
    o = '0;
    if (k == 9) o[10] = 1'b1;
    else if (k == 11) o[11] = 1'b1;
    else begin
      digit = (k == 10) ? 0 : k + 1;
      o[digit] = 1'b1;
    end
    return o;
  endfunction

  // ---------------- behavioural model ----------------
  // m counts clock intervals since the last reset edge. The scanner samples, on the
  // last clock of each slot, the pad level from two intervals earlier (synchronizer).
  bit          armed = 1'b0;
  int unsigned m;
  logic [2:0]  p1, p2;          // pad levels one and two intervals back
  int          acc_lows, acc_key;
  int          cand, cnt, held, mst;  // mst: 0 idle, 1 held, 2 releasing
  logic [11:0] e_out;
  bit          e_strobe;

  always @(negedge clk) begin
    logic [3:0] e_row;
    logic [2:0] colm, smp;
    int r, code;
    bit hit;
    if (armed) begin
      e_row = 4'b0001 << ((m / SD) % 4);
      e_row = ~e_row;
      check("row_n", row_n, e_row);
      check("keypad", keypad, e_out[9:0]);
      check("star", star, e_out[10]);
      check("hash", hash, e_out[11]);
      check("key_strobe", key_strobe, e_strobe);
    end
    if (clearn === 1'b0) begin
      armed = 1'b1;
      m = 0;
      p1 = 3'b111;
      p2 = 3'b111;
      acc_lows = 0;
      acc_key = 0;
      cand = -1;
      cnt = 0;
      held = -1;
      mst = 0;
      e_out = '0;
      e_strobe = 1'b0;
    end else if (armed) begin
      e_strobe = 1'b0;
      r = (m / SD) % 4;
      colm = 3'b111;
      for (int c = 0; c < 3; c++) if (pressed[r*3+c]) colm[c] = 1'b0;
      if (m % SD == SD - 1) begin
        smp = p2;
        for (int c = 0; c < 3; c++) begin
          if (!smp[c]) begin
            acc_lows++;
            acc_key = r * 3 + c;
          end
        end
      end
      if (m % FRAME == FRAME - 1) begin
        code = (acc_lows == 1) ? acc_key : -1;
        acc_lows = 0;
        if (code == cand) begin
          if (cnt < DF) cnt++;
        end else begin
          cand = code;
          cnt = 1;
        end
        hit = (cnt == DF);
        case (mst)
          0: if (hit && cand >= 0) begin
            mst = 1;
            held = cand;
            e_out = key_outputs(cand);
            e_strobe = 1'b1;
          end
          1: if (code != held) mst = 2;
          default: if (hit) begin
            if (cand < 0) begin
              mst = 0;
              e_out = '0;
            end else if (cand == held) begin
              mst = 1;
            end else begin
              mst = 1;
              held = cand;
              e_out = key_outputs(cand);
              e_strobe = 1'b1;
            end
          end
        endcase
      end
      p2 = p1;
      p1 = colm;
      m++;
    end
  end

  // ---------------- event monitor ----------------
  int n_strobe = 0, n_odd = 0, n_zero = 0;
  logic [9:0] allow_kp = '0;

  always @(negedge clk) begin
    if (armed) begin
      if (key_strobe === 1'b1) n_strobe++;
      if (keypad !== 10'd0 && keypad !== allow_kp) n_odd++;
      if (keypad === 10'd0) n_zero++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string name, input logic [11:0] want, input int limit,
                          output int waited);
    bit found;
    found = 1'b0;
    waited = 0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      waited = i;
      if ({hash, star, keypad} === want) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s: outputs %0h, expected %0h within %0d clks", name,
               {hash, star, keypad}, want, limit);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w, s0, z0, o0;
    clearn = 1'b0;
    pressed = '0;
    tick(2);
    clearn = 1'b1;

    // 1: reset values and row stepping
    @(negedge clk);
    check("t1_row0", row_n, 4'b1110);
    check("t1_keypad", keypad, 10'd0);
    check("t1_flags", {star, hash, key_strobe}, 3'b000);
    repeat (SD) @(negedge clk);
    check("t1_row1", row_n, 4'b1101);
    repeat (SD) @(negedge clk);
    check("t1_row2", row_n, 4'b1011);
    repeat (SD) @(negedge clk);
    check("t1_row3", row_n, 4'b0111);
    repeat (SD) @(negedge clk);
    check("t1_wrap", row_n, 4'b1110);
    tick(3);

    // 2: hold '5'
    s0 = n_strobe;
    pressed[K5] = 1'b1;
    wait_out("t2_commit5", 12'b0000_0010_0000, 67, w);
    check("t2_keypad", keypad, 10'b0000100000);
    tick(40);
    check("t2_still_held", keypad, 10'b0000100000);
    check("t2_one_strobe", n_strobe - s0, 1);

    // 5a: release '5'
    s0 = n_strobe;
    pressed[K5] = 1'b0;
    wait_out("t5_release5", 12'd0, 67, w);
    check("t5_release_no_strobe", n_strobe - s0, 0);
    tick(20);

    // 3: bouncing '0'
    s0 = n_strobe;
    o0 = n_odd;
    allow_kp = 10'b0000000001;
    for (int i = 0; i < 8; i++) begin
      pressed[K0] = (i % 2 == 0);
      tick(5);
    end
    pressed[K0] = 1'b1;
    wait_out("t3_commit0", 12'b0000_0000_0001, 100, w);
    check("t3_keypad", keypad, 10'b0000000001);
    tick(2 * FRAME);
    check("t3_one_strobe", n_strobe - s0, 1);
    check("t3_no_other_value", n_odd - o0, 0);
    pressed[K0] = 1'b0;
    wait_out("t3_release", 12'd0, 67, w);
    tick(20);

    // 4: '1' and '3' together, then release '3'
    s0 = n_strobe;
    pressed[K1] = 1'b1;
    pressed[K3] = 1'b1;
    tick(80);
    check("t4_multi_outputs", {hash, star, keypad}, 12'd0);
    check("t4_multi_no_strobe", n_strobe - s0, 0);
    pressed[K3] = 1'b0;
    wait_out("t4_commit1", 12'b0000_0000_0010, 67, w);
    check("t4_keypad", keypad, 10'b0000000010);
    check("t4_one_strobe", n_strobe - s0, 1);
    pressed[K1] = 1'b0;
    wait_out("t4_release", 12'd0, 67, w);
    tick(20);

    // 5b: '*'
    s0 = n_strobe;
    pressed[KSTAR] = 1'b1;
    wait_out("t5_star", 12'b0100_0000_0000, 67, w);
    check("t5_star_level", star, 1'b1);
    check("t5_star_keypad", keypad, 10'd0);
    check("t5_star_strobe", n_strobe - s0, 1);
    pressed[KSTAR] = 1'b0;
    wait_out("t5_star_release", 12'd0, 67, w);
    tick(20);

    // 5c: slide '7' -> '8'
    pressed[K7] = 1'b1;
    wait_out("t5_commit7", 12'b0000_1000_0000, 67, w);
    s0 = n_strobe;
    z0 = n_zero;
    pressed = '0;
    pressed[K8] = 1'b1;
    wait_out("t5_slide8", 12'b0001_0000_0000, 67, w);
    check("t5_slide_keypad", keypad, 10'b0100000000);
    check("t5_slide_strobe", n_strobe - s0, 1);
    check("t5_slide_no_gap", n_zero - z0, 0);
    pressed[K8] = 1'b0;
    wait_out("t5_slide_release", 12'd0, 67, w);
    tick(20);

    // 6: reset while '9' held
    pressed[K9] = 1'b1;
    wait_out("t6_commit9", 12'b0010_0000_0000, 67, w);
    clearn = 1'b0;
    tick(1);
    check("t6_reset_row", row_n, 4'b1110);
    check("t6_reset_outputs", {hash, star, keypad}, 12'd0);
    check("t6_reset_strobe", key_strobe, 1'b0);
    clearn = 1'b1;
    s0 = n_strobe;
    wait_out("t6_recommit9", 12'b0010_0000_0000, 80, w);
    check("t6_min_frames", (w >= DF * FRAME), 1'b1);
    check("t6_new_strobe", n_strobe - s0, 1);
    pressed[K9] = 1'b0;
    wait_out("t6_release", 12'd0, 67, w);
    tick(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
